// File: rtl/fsm_event_logger_pkg.sv
// Shared definitions for the FSM event logger.
//   - FSM state encodings as seen on fsm_state
//   - 32-bit trace record layout (struct + field positions)
//   - overflow counter saturation value
package fsm_event_logger_pkg;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10,
    ST_LOCK  = 2'b11
  } fsm_state_e;

  localparam int REC_W         = 32;
  localparam int REC_PREV_MSB  = 31;
  localparam int REC_PREV_LSB  = 30;
  localparam int REC_CUR_MSB   = 29;
  localparam int REC_CUR_LSB   = 28;
  localparam int REC_INSTR_MSB = 27;
  localparam int REC_INSTR_LSB = 25;
  localparam int REC_ENT_MSB   = 24;
  localparam int REC_ENT_LSB   = 17;
  localparam int REC_LOCK_BIT  = 16;
  localparam int REC_TS_MSB    = 15;
  localparam int REC_TS_LSB    = 0;

  localparam logic [7:0] OVF_SAT = 8'hFF;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic [1:0] prev;
    logic [1:0] cur;
    logic [2:0] instr;
    logic [7:0] entropy;
    logic       lock;
    logic [15:0] ts;
  } rec_t;

endpackage

// File: rtl/fsm_event_logger_if.sv
// Record stream between the logger and a trace/debug sink.
//   rec_valid : head record available (logger -> sink)
//   rec_data  : head record, 0 when nothing is held (logger -> sink)
//   rec_ready : sink takes the head record this edge (sink -> logger)
interface fsm_event_logger_if;
  import fsm_event_logger_pkg::*;

  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/fsm_event_logger_fifo.sv
// logger_fifo: synchronous show-ahead FIFO.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous flush, wins over push/pop
//   push, din  : write request; accepted if not full or if a pop frees a slot
//   pop        : read request; ignored when empty
//   dout       : head entry, 0 when empty
//   full, empty, level : occupancy status
module logger_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);

  assign dout  = empty ? '0 : mem_q[rd_q];
  assign level = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else if (clr) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/fsm_event_logger.sv
// fsm_event_logger: packs each FSM state change into a timestamped 32-bit
// record and queues it for a trace sink.
//   clk, rst_n         : clock, async active-low reset
//   enable             : capture enable (prev-state tracking runs regardless)
//   clear              : sync flush of FIFO, timestamp and overflow status
//   fsm_state, fsm_entropy_log, fsm_instr_type_log, lock_in : captured fields
//   rec                : record stream (valid/ready/data), master side
//   fifo_level         : records queued
//   overflow_cnt       : dropped records, saturating
//   overflow_sticky    : set on first drop
module fsm_event_logger
  import fsm_event_logger_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [1:0]             fsm_state,
  input  logic [7:0]             fsm_entropy_log,
  input  logic [2:0]             fsm_instr_type_log,
  input  logic                   lock_in,
  fsm_event_logger_if.master     rec,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             overflow_cnt,
  output logic                   overflow_sticky
);
  logic [1:0]      prev_state_q;
  logic [TS_W-1:0] ts_q;
  logic [7:0]      ovf_cnt_q;
  logic            sticky_q;

  logic evt, pop, full, empty, drop;
  rec_t rec_w;

  // A transition in a clear cycle is discarded along with everything else.
  assign evt  = enable && (fsm_state != prev_state_q) && !clear;
  assign pop  = rec.rec_ready && !empty;
  assign drop = evt && full && !pop;

  assign rec_w = '{prev: prev_state_q, cur: fsm_state, instr: fsm_instr_type_log,
                   entropy: fsm_entropy_log, lock: lock_in, ts: ts_q[15:0]};

  logger_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .push  (evt),
    .din   (rec_w),
    .pop   (pop),
    .dout  (rec.rec_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Valid comes from registered occupancy only, never from rec_ready.
  assign rec.rec_valid   = !empty;
  assign overflow_cnt    = ovf_cnt_q;
  assign overflow_sticky = sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state_q <= ST_OK;
      ts_q         <= '0;
      ovf_cnt_q    <= '0;
      sticky_q     <= 1'b0;
    end else begin
      prev_state_q <= fsm_state;
      if (clear) begin
        ts_q      <= '0;
        ovf_cnt_q <= '0;
        sticky_q  <= 1'b0;
      end else begin
        ts_q <= ts_q + 1'b1;
        if (drop) begin
          sticky_q <= 1'b1;
          if (ovf_cnt_q != OVF_SAT) ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fsm_event_logger.sv
module tb_fsm_event_logger;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0, clear = 1'b0, lock_in = 1'b0;
  logic [1:0]    fsm_state = 2'b00;
  logic [7:0]    ent = 8'h00;
  logic [2:0]    ins = 3'b000;
  logic [LW-1:0] fifo_level;
  logic [7:0]    ovf;
  logic          sticky;

  fsm_event_logger_if rif();

  fsm_event_logger #(.DEPTH(DEPTH), .TS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .fsm_state(fsm_state), .fsm_entropy_log(ent), .fsm_instr_type_log(ins),
    .lock_in(lock_in), .rec(rif), .fifo_level(fifo_level),
    .overflow_cnt(ovf), .overflow_sticky(sticky)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of records plus plain counters.
  logic [31:0] mq[$];
  logic [15:0] m_ts;
  int          m_ovf;
  bit          m_sticky;
  logic [1:0]  m_prev;

  int errors = 0, checks = 0;

  typedef struct {
    logic [1:0]  st;
    logic [7:0]  ent;
    logic [2:0]  ins;
    logic        lck, en, rdy, clr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [LW-1:0] exp_level;
  } vec_t;

  function automatic logic [31:0] mkrec(logic [1:0] p, logic [1:0] c, logic [2:0] i,
                                        logic [7:0] e, logic l, logic [15:0] t);
    return {p, c, i, e, l, t};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete(); m_ts = 0; m_ovf = 0; m_sticky = 0; m_prev = 2'b00;
  endtask

  // One rising edge of the specified behaviour, using the inputs as driven now.
  task automatic model_edge();
    bit full, pop, ev;
    if (clear) begin
      mq.delete(); m_ts = 0; m_ovf = 0; m_sticky = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && rif.rec_ready;
      ev   = enable && (fsm_state != m_prev);
      if (pop) void'(mq.pop_front());
      if (ev) begin
        if (!full || pop) mq.push_back(mkrec(m_prev, fsm_state, ins, ent, lock_in, m_ts));
        else begin
          m_sticky = 1;
          if (m_ovf < 255) m_ovf++;
        end
      end
      m_ts = m_ts + 16'd1;
    end
    m_prev = fsm_state;
  endtask

  task automatic compare_all();
    chk("valid",  {31'd0, rif.rec_valid}, {31'd0, mq.size() > 0});
    chk("data",   rif.rec_data, (mq.size() > 0) ? mq[0] : 32'd0);
    chk("level",  32'(fifo_level), 32'(mq.size()));
    chk("ovf",    32'(ovf), 32'(m_ovf));
    chk("sticky", {31'd0, sticky}, {31'd0, m_sticky});
  endtask

  task automatic step(bit do_chk);
    model_edge();
    @(posedge clk); #1;
    if (do_chk) compare_all();
  endtask

  task automatic drive(logic [1:0] st, logic en, logic rdy, logic clr);
    fsm_state = st; enable = en; rif.rec_ready = rdy; clear = clr;
    ent = 8'($urandom); ins = 3'($urandom); lock_in = 1'($urandom);
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(string name);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk({name, "_valid"}, {31'd0, rif.rec_valid}, 32'd0);
    chk({name, "_data"},  rif.rec_data, 32'd0);
    chk({name, "_level"}, 32'(fifo_level), 32'd0);
    chk({name, "_ovf"},   32'(ovf), 32'd0);
    chk({name, "_sticky"},{31'd0, sticky}, 32'd0);
    fsm_state = 2'b00; clear = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  vec_t        vt[8];
  logic [31:0] r1, r2, r3;
  logic [15:0] t1;

  initial begin
    rif.rec_ready = 1'b0;
    enable = 1'b1;
    // Reset state
    async_reset("reset");

    // Test 1: table of vectors; transition at the edge carrying ts=5.
    for (int i = 0; i < 8; i++)
      vt[i] = '{st: 2'b00, ent: 8'h00, ins: 3'b000, lck: 1'b0, en: 1'b1, rdy: 1'b0,
                clr: 1'b0, exp_valid: 1'b0, exp_data: 32'd0, exp_level: '0};
    r1 = mkrec(2'b00, 2'b01, 3'b010, 8'hC8, 1'b0, 16'd5);
    vt[5] = '{2'b01, 8'hC8, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, r1, LW'(1)};
    vt[6] = '{2'b01, 8'h11, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, r1, LW'(1)};
    vt[7] = '{2'b01, 8'h22, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, LW'(0)};
    for (int i = 0; i < 8; i++) begin
      fsm_state = vt[i].st; ent = vt[i].ent; ins = vt[i].ins; lock_in = vt[i].lck;
      enable = vt[i].en; rif.rec_ready = vt[i].rdy; clear = vt[i].clr;
      step(1);
      chk($sformatf("vec%0d_valid", i), {31'd0, rif.rec_valid}, {31'd0, vt[i].exp_valid});
      chk($sformatf("vec%0d_data", i), rif.rec_data, vt[i].exp_data);
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vt[i].exp_level));
    end

    // Test 2: ten transitions into a stalled sink.
    drive(2'b01, 1, 0, 1); step(1);
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 2'b00 : 2'b01, 1, 0, 0);
      if (i == 0) r1 = mkrec(2'b01, 2'b00, ins, ent, lock_in, 16'd0);
      if (i == 1) r2 = mkrec(2'b00, 2'b01, ins, ent, lock_in, 16'd1);
      step(1);
    end
    chk("fill_level",  32'(fifo_level), 32'd8);
    chk("fill_ovf",    32'(ovf), 32'd2);
    chk("fill_sticky", {31'd0, sticky}, 32'd1);
    chk("fill_head",   rif.rec_data, r1);

    // Test 3: full, pop and push together.
    drive(2'b00, 1, 1, 0); step(1);
    chk("fullpp_level", 32'(fifo_level), 32'd8);
    chk("fullpp_ovf",   32'(ovf), 32'd2);
    chk("fullpp_head",  rif.rec_data, r2);

    // Test 4: disabled transition updates prev-state only.
    for (int i = 0; i < 8; i++) begin drive(2'b00, 1, 1, 0); step(1); end
    drive(2'b01, 1, 0, 0); step(1);
    drive(2'b11, 0, 0, 0); step(1);
    chk("dis_level", 32'(fifo_level), 32'd1);
    drive(2'b11, 1, 0, 0); step(1);
    chk("dis_nochg_level", 32'(fifo_level), 32'd1);
    drive(2'b00, 1, 0, 0); t1 = m_ts;
    r3 = mkrec(2'b11, 2'b00, ins, ent, lock_in, t1);
    step(1);
    drive(2'b00, 1, 1, 0); step(1);
    chk("dis_prev11", rif.rec_data, r3);

    // Test 5: timestamp wrap.
    drive(2'b00, 1, 1, 1); step(1);
    while (m_ts != 16'hFFFE) begin drive(2'b00, 1, 1, 0); step(0); end
    drive(2'b01, 1, 0, 0); step(1);
    drive(2'b10, 1, 0, 0); step(1);
    drive(2'b10, 1, 0, 0); step(1);
    drive(2'b11, 1, 0, 0); step(1);
    chk("wrap_ts0", 32'(rif.rec_data[15:0]), 32'h0000FFFE);
    drive(2'b11, 1, 1, 0); step(1);
    chk("wrap_ts1", 32'(rif.rec_data[15:0]), 32'h0000FFFF);
    drive(2'b11, 1, 1, 0); step(1);
    chk("wrap_ts2", 32'(rif.rec_data[15:0]), 32'h00000001);

    // Test 6: clear beats a same-cycle transition.
    drive(2'b11, 1, 1, 1); step(1);
    for (int i = 0; i < 11; i++) begin drive((i % 2 == 0) ? 2'b00 : 2'b11, 1, 0, 0); step(1); end
    for (int i = 0; i < 3; i++) begin drive(2'b00, 1, 1, 0); step(1); end
    chk("pre_clr_level", 32'(fifo_level), 32'd5);
    chk("pre_clr_ovf",   32'(ovf), 32'd3);
    drive(2'b10, 1, 1, 1); step(1);
    chk("clr_level",  32'(fifo_level), 32'd0);
    chk("clr_ovf",    32'(ovf), 32'd0);
    chk("clr_sticky", {31'd0, sticky}, 32'd0);
    chk("clr_valid",  {31'd0, rif.rec_valid}, 32'd0);
    drive(2'b01, 1, 0, 0); step(1);
    chk("post_clr_prev", 32'(rif.rec_data[31:30]), 32'd2);
    chk("post_clr_ts",   32'(rif.rec_data[15:0]), 32'd0);

    // Overflow counter saturation.
    for (int i = 0; i < 280; i++) begin drive((i % 2 == 0) ? 2'b10 : 2'b01, 1, 0, 0); step(0); end
    compare_all();
    chk("ovf_sat", 32'(ovf), 32'd255);

    // Random traffic against the model, with an async reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      drive(2'($urandom), ($urandom_range(7) != 0), 1'($urandom),
            ($urandom_range(63) == 0));
      step(1);
      if (i == 1500) async_reset("midrst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fsm_event_logger.md
Name: fsm_event_logger

Overview:
- Consumer side of the entropy-aware FSM's state-change log in archon_top.
- Watches FSM state transitions and packs each one, with the logged entropy and instruction type, into a 32-bit timestamped record.
- Records are buffered in a FIFO and drained by a trace/debug sink over a valid/ready interface.
- Replaces testbench-side $monitor scraping with an on-chip, lossless-until-full trace path.

Parameters:
- DEPTH, 8, FIFO depth in records; power of two, minimum 2.
- TS_W, 16, timestamp counter width; fixed at 16 for the 32-bit record format.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- enable  in  1  capture enable; when low, transitions are ignored but prev-state tracking continues
- clear  in  1  synchronous clear of FIFO, timestamp, overflow counter and sticky flag
- fsm_state  in  2  current FSM state (00 OK, 01 STALL, 10 FLUSH, 11 LOCK)
- fsm_entropy_log  in  8  entropy value logged by the FSM
- fsm_instr_type_log  in  3  instruction type logged by the FSM
- lock_in  in  1  system lock status
- rec_valid  out  1  head record available
- rec_ready  in  1  sink accepts the head record
- rec_data  out  32  head record
- fifo_level  out  clog2(DEPTH)+1  current occupancy
- overflow_cnt  out  8  dropped-event count, saturating at 255
- overflow_sticky  out  1  set on the first drop; cleared only by clear or reset

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; rec_valid=0; rec_data=0; fifo_level=0.
  - overflow_cnt=0; overflow_sticky=0; timestamp=0; prev_state_q=2'b00.
- Timestamp: free-running TS_W counter, +1 every cycle; wraps 0xFFFF->0x0000.
- Event detection:
  - event = enable && (fsm_state != prev_state_q), evaluated at each rising edge.
  - prev_state_q <= fsm_state every cycle regardless of enable.
- Record format, captured at the event edge from current inputs:
  - [31:30] prev_state_q
  - [29:28] fsm_state
  - [27:25] fsm_instr_type_log
  - [24:17] fsm_entropy_log
  - [16] lock_in
  - [15:0] timestamp value before that edge's increment
- Latency: a state change visible before edge N gives rec_valid=1 after edge N if the FIFO was empty. At most one record per cycle.
- FIFO output is show-ahead:
  - rec_data = head entry while rec_valid = !empty; rec_data=0 when empty.
  - Pop occurs on rec_valid && rec_ready at the edge.
  - rec_data is stable while rec_valid=1 and rec_ready=0.
- Full and empty:
  - Push when full with no pop in the same cycle: record dropped, overflow_cnt +1 (saturating at 255), overflow_sticky=1.
  - Push and pop in the same cycle when full: both happen, nothing dropped, level unchanged.
  - Push and pop in the same cycle at any other level: level unchanged.
  - rec_ready while empty: no effect.
- Pointers are clog2(DEPTH) bits and wrap naturally; level is tracked separately (or via an extra pointer bit) to tell full from empty.
- clear has priority over push and pop:
  - Empties the FIFO and zeroes timestamp, overflow_cnt and overflow_sticky.
  - Does not alter prev_state_q.
  - A transition in the clear cycle is not recorded.
- Reset mid-operation: all contents lost immediately (async); no partial record is ever presented.
- No combinational path from rec_ready to rec_valid.

Decomposition:
- archon_pkg:
  - FSM state encodings: ST_OK, ST_STALL, ST_FLUSH, ST_LOCK.
  - Record field bit positions and widths (REC_PREV_MSB etc.).
  - Overflow saturation constant (8'hFF).
- Sub-module logger_fifo:
  - Parameterised synchronous show-ahead FIFO with push, pop, full, empty and level.
  - Top level holds event detection, timestamp and overflow logic.

Test Plan:
1. Reset, then fsm_state 00->01 at cycle 5 with entropy 0xC8, instr 3'b010, lock 0, rec_ready=0 -> rec_valid=1 one edge later; rec_data={2'b00,2'b01,3'b010,8'hC8,1'b0,16'd5}; level=1.
2. DEPTH=8, rec_ready=0, 10 alternating transitions -> level=8; overflow_cnt=2; overflow_sticky=1; head record is the first event.
3. FIFO full with rec_ready=1 while a transition occurs -> level stays 8; overflow_cnt unchanged; the popped record is the oldest.
4. enable=0 during 01->11 then enable=1 with no further change -> no record; the next change 11->00 records prev=11.
5. Timestamp at 0xFFFE and transitions on two consecutive edges -> records carry 0xFFFE and 0xFFFF; a transition two cycles later carries 0x0001.
6. clear asserted while level=5, overflow_cnt=3, and a transition in the same cycle -> level=0; overflow_cnt=0; sticky=0; no new record; next event timestamp counts from 0.
